// File: rtl/mc_pkg.sv
// Memory-controller definitions shared by the APB config block, fsm_ctrl and the
// refresh scheduler: config widths, pending-refresh limit, scheduler state encoding.
package mc_pkg;

   localparam int MC_REFI_WIDTH = 16;
   localparam int MC_PEND_WIDTH = 4;
   localparam int MC_PEND_MAX   = 8;

   typedef enum logic [1:0] {
      RF_SCH_IDLE  = 2'd0,
      RF_SCH_REQ   = 2'd1,
      RF_SCH_START = 2'd2,
      RF_SCH_WAIT  = 2'd3
   } rf_sch_state_e;

endpackage

// File: rtl/rf_interval_timer.sv
// Refresh interval timer: counts 0..cfg-1 while enabled and flags the last count
// as a tick; held at 0 when disabled or when the interval is programmed to 0.
module rf_interval_timer
   import mc_pkg::*;
#(
   parameter int REFI_WIDTH = MC_REFI_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic [REFI_WIDTH-1:0] cfg_i,
   output logic                  tick_o
);

   logic [REFI_WIDTH-1:0] count_q;
   logic [REFI_WIDTH-1:0] count_d;
   logic                  run;
   logic                  at_end;

   // >= rather than == so a shrinking interval wraps at once instead of overrunning
   always_comb begin
      run     = en_i && (cfg_i != '0);
      at_end  = (count_q >= (cfg_i - REFI_WIDTH'(1)));
      count_d = '0;
      if (run && !at_end) begin
         count_d = count_q + REFI_WIDTH'(1);
      end
   end

   assign tick_o = run && at_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/array_rf_sched.sv
// Refresh scheduler: accumulates owed refreshes from the interval timer, requests
// an array slot from fsm_ctrl and runs one rf_start/rf_done burst per grant.
module array_rf_sched
   import mc_pkg::*;
#(
   parameter int REFI_WIDTH = MC_REFI_WIDTH,
   parameter int PEND_MAX   = MC_PEND_MAX,
   parameter int PEND_WIDTH = MC_PEND_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mc_rf_en,
   input  logic [REFI_WIDTH-1:0] mc_trefi_cfg,
   input  logic [PEND_WIDTH-1:0] mc_rf_urg_cfg,
   output logic                  rf_req,
   output logic                  rf_urgent,
   input  logic                  rf_grant,
   output logic                  rf_start,
   input  logic                  rf_done,
   output logic                  rf_busy,
   output logic [PEND_WIDTH-1:0] rf_pend_cnt,
   output logic                  rf_overflow
);

   localparam logic [PEND_WIDTH-1:0] PEND_SAT = PEND_WIDTH'(PEND_MAX);

   rf_sch_state_e         state_q;
   rf_sch_state_e         state_d;
   logic [PEND_WIDTH-1:0] pend_q;
   logic [PEND_WIDTH-1:0] pend_d;
   logic                  ovf_q;
   logic                  ovf_d;
   logic                  req_q;
   logic                  start_q;
   logic                  busy_q;
   logic                  urg_q;
   logic                  tick;
   logic                  done_acc;

   rf_interval_timer #(
      .REFI_WIDTH (REFI_WIDTH)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (mc_rf_en),
      .cfg_i  (mc_trefi_cfg),
      .tick_o (tick)
   );

   assign done_acc = rf_done && (state_q == RF_SCH_WAIT);

   // A tick and an accepted done in the same cycle cancel out
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (!mc_rf_en) begin
         pend_d = '0;
         ovf_d  = 1'b0;
      end else if (tick && !done_acc) begin
         if (pend_q >= PEND_SAT) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PEND_WIDTH'(1);
         end
      end else if (done_acc && !tick && (pend_q != '0)) begin
         pend_d = pend_q - PEND_WIDTH'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RF_SCH_IDLE: begin
            if ((pend_q != '0) && mc_rf_en) begin
               state_d = RF_SCH_REQ;
            end
         end
         RF_SCH_REQ: begin
            if (!mc_rf_en) begin
               state_d = RF_SCH_IDLE;
            end else if (rf_grant) begin
               state_d = RF_SCH_START;
            end
         end
         RF_SCH_START: state_d = RF_SCH_WAIT;
         RF_SCH_WAIT: begin
            if (rf_done) begin
               state_d = RF_SCH_IDLE;
            end
         end
         default: state_d = RF_SCH_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RF_SCH_IDLE;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         req_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         urg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         req_q   <= (state_d == RF_SCH_REQ);
         start_q <= (state_d == RF_SCH_START);
         busy_q  <= (state_d == RF_SCH_START) || (state_d == RF_SCH_WAIT);
         urg_q   <= (mc_rf_urg_cfg != '0) && (pend_q >= mc_rf_urg_cfg);
      end
   end

   assign rf_req      = req_q;
   assign rf_urgent   = urg_q;
   assign rf_start    = start_q;
   assign rf_busy     = busy_q;
   assign rf_pend_cnt = pend_q;
   assign rf_overflow = ovf_q;

endmodule

// File: tb/tb_array_rf_sched.sv
// Directed bench for array_rf_sched: periodic refresh, saturation, tick/done
// collision, disable in REQ and WAIT, and asynchronous reset mid-burst.
module tb_array_rf_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mc_rf_en;
   logic [15:0] mc_trefi_cfg;
   logic [3:0]  mc_rf_urg_cfg;
   logic        rf_req;
   logic        rf_urgent;
   logic        rf_grant;
   logic        rf_start;
   logic        rf_done;
   logic        rf_busy;
   logic [3:0]  rf_pend_cnt;
   logic        rf_overflow;

   int n_cmp = 0;
   int n_err = 0;

   int start_times[$];
   int max_pend;
   bit ovf_seen;
   bit start_double;

   always #5 clk = ~clk;

   array_rf_sched dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mc_rf_en      (mc_rf_en),
      .mc_trefi_cfg  (mc_trefi_cfg),
      .mc_rf_urg_cfg (mc_rf_urg_cfg),
      .rf_req        (rf_req),
      .rf_urgent     (rf_urgent),
      .rf_grant      (rf_grant),
      .rf_start      (rf_start),
      .rf_done       (rf_done),
      .rf_busy       (rf_busy),
      .rf_pend_cnt   (rf_pend_cnt),
      .rf_overflow   (rf_overflow)
   );

   // Responder acting as fsm_ctrl and refresh controller: grants gdly cycles after
   // seeing rf_req, answers rf_done ddly cycles after rf_start. Records start times.
   task automatic serve(input int ncyc, input int gdly, input int ddly);
      int grant_at;
      int done_at;
      bit prev_start;
      grant_at = -100;
      done_at = -100;
      prev_start = 1'b0;
      start_times.delete();
      max_pend = 0;
      ovf_seen = 1'b0;
      start_double = 1'b0;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         if (int'(rf_pend_cnt) > max_pend) max_pend = int'(rf_pend_cnt);
         if (rf_overflow) ovf_seen = 1'b1;
         if (rf_start) begin
            start_times.push_back(i);
            done_at = i + ddly;
            if (prev_start) start_double = 1'b1;
         end
         prev_start = rf_start;
         if (rf_req && grant_at < i) grant_at = i + gdly;
         rf_grant = (i == grant_at);
         rf_done = (i == done_at);
      end
      rf_grant = 1'b0;
      rf_done = 1'b0;
   endtask

   task automatic quiesce();
      rf_grant = 1'b0;
      rf_done = 1'b0;
      mc_rf_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mc_rf_en = 1'b0;
      mc_trefi_cfg = 16'd0;
      mc_rf_urg_cfg = 4'd0;
      rf_grant = 1'b0;
      rf_done = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({rf_req, rf_urgent, rf_start, rf_busy, rf_overflow, rf_pend_cnt} !== 9'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected 0", {rf_req, rf_urgent, rf_start, rf_busy, rf_overflow, rf_pend_cnt});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({rf_req, rf_urgent, rf_start, rf_busy, rf_overflow, rf_pend_cnt} !== 9'd0) begin
         n_err++;
         $display("FAIL post_reset_idle: got %b expected 0", {rf_req, rf_urgent, rf_start, rf_busy, rf_overflow, rf_pend_cnt});
      end
      $display("reset: outputs checked during and after reset");
   endtask

   task automatic test_periodic();
      quiesce();
      mc_trefi_cfg = 16'd10;
      mc_rf_urg_cfg = 4'd0;
      mc_rf_en = 1'b1;
      serve(50, 2, 5);
      n_cmp++;
      if (start_times.size() !== 4) begin
         n_err++;
         $display("FAIL periodic_count: got %0d starts expected 4", start_times.size());
      end
      if (start_times.size() > 0) begin
         n_cmp++;
         if (start_times[0] !== 14) begin
            n_err++;
            $display("FAIL periodic_first: got cycle %0d expected 14", start_times[0]);
         end
      end
      for (int k = 1; k < start_times.size(); k++) begin
         n_cmp++;
         if (start_times[k] - start_times[k-1] !== 10) begin
            n_err++;
            $display("FAIL periodic_gap%0d: got %0d expected 10", k, start_times[k] - start_times[k-1]);
         end
      end
      n_cmp++;
      if (max_pend !== 1) begin
         n_err++;
         $display("FAIL periodic_max_pend: got %0d expected 1", max_pend);
      end
      n_cmp++;
      if (ovf_seen !== 1'b0 || start_double !== 1'b0) begin
         n_err++;
         $display("FAIL periodic_ovf_or_wide_start: got ovf=%0d double=%0d expected 0 0", ovf_seen, start_double);
      end
      $display("periodic: %0d starts, max pend %0d", start_times.size(), max_pend);
   endtask

   task automatic test_saturate();
      bit any_start;
      quiesce();
      any_start = 1'b0;
      mc_trefi_cfg = 16'd4;
      mc_rf_urg_cfg = 4'd6;
      mc_rf_en = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (rf_start) any_start = 1'b1;
         if (c == 5) begin
            n_cmp++;
            if (rf_req !== 1'b1) begin n_err++; $display("FAIL sat_req: got %0d expected 1", rf_req); end
         end
         if (c == 24) begin
            n_cmp++;
            if (rf_pend_cnt !== 4'd6 || rf_urgent !== 1'b0) begin
               n_err++;
               $display("FAIL sat_pend6: got pend=%0d urg=%0d expected 6 0", rf_pend_cnt, rf_urgent);
            end
         end
         if (c == 25) begin
            n_cmp++;
            if (rf_urgent !== 1'b1) begin n_err++; $display("FAIL sat_urgent: got %0d expected 1", rf_urgent); end
         end
         if (c == 30) rf_done = 1'b1;
         if (c == 31) begin
            rf_done = 1'b0;
            n_cmp++;
            if (rf_pend_cnt !== 4'd7) begin n_err++; $display("FAIL sat_spurious_done: got %0d expected 7", rf_pend_cnt); end
         end
         if (c == 35) begin
            n_cmp++;
            if (rf_overflow !== 1'b0 || rf_pend_cnt !== 4'd8) begin
               n_err++;
               $display("FAIL sat_pre_ovf: got ovf=%0d pend=%0d expected 0 8", rf_overflow, rf_pend_cnt);
            end
         end
         if (c == 36) begin
            n_cmp++;
            if (rf_overflow !== 1'b1 || rf_pend_cnt !== 4'd8) begin
               n_err++;
               $display("FAIL sat_ovf: got ovf=%0d pend=%0d expected 1 8", rf_overflow, rf_pend_cnt);
            end
         end
      end
      n_cmp++;
      if (any_start !== 1'b0) begin n_err++; $display("FAIL sat_no_start: got %0d expected 0", any_start); end
      mc_trefi_cfg = 16'd0;
      serve(40, 0, 1);
      n_cmp++;
      if (start_times.size() !== 8) begin
         n_err++;
         $display("FAIL drain_count: got %0d starts expected 8", start_times.size());
      end
      for (int k = 1; k < start_times.size(); k++) begin
         n_cmp++;
         if (start_times[k] - start_times[k-1] !== 4) begin
            n_err++;
            $display("FAIL drain_gap%0d: got %0d expected 4", k, start_times[k] - start_times[k-1]);
         end
      end
      n_cmp++;
      if ({rf_pend_cnt, rf_req, rf_urgent, rf_overflow} !== 7'b0000_001) begin
         n_err++;
         $display("FAIL drain_end: got pend=%0d req=%0d urg=%0d ovf=%0d expected 0 0 0 1", rf_pend_cnt, rf_req, rf_urgent, rf_overflow);
      end
      $display("saturate: drained with %0d starts", start_times.size());
   endtask

   task automatic test_tick_done_collision();
      quiesce();
      n_cmp++;
      if (rf_overflow !== 1'b0 || rf_pend_cnt !== 4'd0) begin
         n_err++;
         $display("FAIL disable_clears: got ovf=%0d pend=%0d expected 0 0", rf_overflow, rf_pend_cnt);
      end
      mc_trefi_cfg = 16'd4;
      mc_rf_urg_cfg = 4'd0;
      mc_rf_en = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         if (c == 12) begin
            n_cmp++;
            if (rf_pend_cnt !== 4'd3) begin n_err++; $display("FAIL coll_pend3: got %0d expected 3", rf_pend_cnt); end
         end
         if (c == 13) rf_grant = 1'b1;
         if (c == 14) begin
            rf_grant = 1'b0;
            n_cmp++;
            if (rf_start !== 1'b1 || rf_req !== 1'b0) begin
               n_err++;
               $display("FAIL coll_start: got start=%0d req=%0d expected 1 0", rf_start, rf_req);
            end
         end
         if (c == 15) rf_done = 1'b1;
         if (c == 16) begin
            rf_done = 1'b0;
            n_cmp++;
            if (rf_pend_cnt !== 4'd3 || rf_busy !== 1'b0 || rf_req !== 1'b0) begin
               n_err++;
               $display("FAIL coll_same_cycle: got pend=%0d busy=%0d req=%0d expected 3 0 0", rf_pend_cnt, rf_busy, rf_req);
            end
         end
         if (c == 17) begin
            n_cmp++;
            if (rf_req !== 1'b1) begin n_err++; $display("FAIL coll_rereq: got %0d expected 1", rf_req); end
         end
      end
      $display("tick_done_collision: pend=%0d", rf_pend_cnt);
   endtask

   task automatic test_disable_req();
      bit any_start;
      quiesce();
      any_start = 1'b0;
      mc_trefi_cfg = 16'd4;
      mc_rf_en = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (rf_start) any_start = 1'b1;
         if (c == 8) begin
            n_cmp++;
            if (rf_pend_cnt !== 4'd2 || rf_req !== 1'b1) begin
               n_err++;
               $display("FAIL dreq_setup: got pend=%0d req=%0d expected 2 1", rf_pend_cnt, rf_req);
            end
         end
         if (c == 9) mc_rf_en = 1'b0;
         if (c == 10) begin
            rf_grant = 1'b1;
            n_cmp++;
            if (rf_req !== 1'b0 || rf_pend_cnt !== 4'd0) begin
               n_err++;
               $display("FAIL dreq_withdraw: got req=%0d pend=%0d expected 0 0", rf_req, rf_pend_cnt);
            end
         end
         if (c == 11) rf_grant = 1'b0;
         if (c == 12) mc_rf_en = 1'b1;
         if (c == 15) begin
            n_cmp++;
            if (rf_pend_cnt !== 4'd0) begin n_err++; $display("FAIL dreq_timer_cleared: got %0d expected 0", rf_pend_cnt); end
         end
         if (c == 16) begin
            n_cmp++;
            if (rf_pend_cnt !== 4'd1) begin n_err++; $display("FAIL dreq_fresh_tick: got %0d expected 1", rf_pend_cnt); end
         end
      end
      n_cmp++;
      if (any_start !== 1'b0) begin n_err++; $display("FAIL dreq_no_start: got %0d expected 0", any_start); end
      $display("disable_req: request withdrawn, timer restarted");
   endtask

   task automatic test_disable_wait();
      quiesce();
      mc_trefi_cfg = 16'd4;
      mc_rf_en = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 5) rf_grant = 1'b1;
         if (c == 6) rf_grant = 1'b0;
         if (c == 7) mc_rf_en = 1'b0;
         if (c == 8) begin
            n_cmp++;
            if (rf_busy !== 1'b1 || rf_pend_cnt !== 4'd0) begin
               n_err++;
               $display("FAIL dwait_inflight: got busy=%0d pend=%0d expected 1 0", rf_busy, rf_pend_cnt);
            end
         end
         if (c == 9) rf_done = 1'b1;
         if (c == 10) begin
            rf_done = 1'b0;
            n_cmp++;
            if (rf_busy !== 1'b0 || rf_pend_cnt !== 4'd0) begin
               n_err++;
               $display("FAIL dwait_done: got busy=%0d pend=%0d expected 0 0", rf_busy, rf_pend_cnt);
            end
         end
         if (c == 11) rf_done = 1'b1;
         if (c == 12) begin
            rf_done = 1'b0;
            rf_grant = 1'b1;
         end
         if (c == 13) begin
            rf_grant = 1'b0;
            n_cmp++;
            if ({rf_busy, rf_start, rf_req, rf_pend_cnt} !== 7'd0) begin
               n_err++;
               $display("FAIL dwait_spurious: got %b expected 0", {rf_busy, rf_start, rf_req, rf_pend_cnt});
            end
         end
      end
      $display("disable_wait: burst completed after disable");
   endtask

   task automatic test_reset_mid_burst();
      bit early_start;
      quiesce();
      early_start = 1'b0;
      mc_trefi_cfg = 16'd4;
      mc_rf_urg_cfg = 4'd3;
      mc_rf_en = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         if (c == 20) begin
            rf_grant = 1'b1;
            n_cmp++;
            if (rf_pend_cnt !== 4'd5) begin n_err++; $display("FAIL rst_setup: got %0d expected 5", rf_pend_cnt); end
         end
         if (c == 21) rf_grant = 1'b0;
      end
      n_cmp++;
      if (rf_busy !== 1'b1 || rf_urgent !== 1'b1) begin
         n_err++;
         $display("FAIL rst_pre: got busy=%0d urg=%0d expected 1 1", rf_busy, rf_urgent);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rf_req, rf_urgent, rf_start, rf_busy, rf_overflow, rf_pend_cnt} !== 9'd0) begin
         n_err++;
         $display("FAIL rst_async: got %b expected 0", {rf_req, rf_urgent, rf_start, rf_busy, rf_overflow, rf_pend_cnt});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int r = 1; r <= 6; r++) begin
         @(negedge clk);
         if (r < 6 && rf_start) early_start = 1'b1;
         if (r == 3) begin
            n_cmp++;
            if (rf_pend_cnt !== 4'd0) begin n_err++; $display("FAIL rst_fresh_pend0: got %0d expected 0", rf_pend_cnt); end
         end
         if (r == 4) begin
            n_cmp++;
            if (rf_pend_cnt !== 4'd1) begin n_err++; $display("FAIL rst_fresh_pend1: got %0d expected 1", rf_pend_cnt); end
         end
         if (r == 5) begin
            rf_grant = 1'b1;
            n_cmp++;
            if (rf_req !== 1'b1) begin n_err++; $display("FAIL rst_req: got %0d expected 1", rf_req); end
         end
         if (r == 6) begin
            rf_grant = 1'b0;
            n_cmp++;
            if (rf_start !== 1'b1) begin n_err++; $display("FAIL rst_first_start: got %0d expected 1", rf_start); end
         end
      end
      n_cmp++;
      if (early_start !== 1'b0) begin n_err++; $display("FAIL rst_early_start: got %0d expected 0", early_start); end
      $display("reset_mid_burst: restart after fresh interval");
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_saturate();
      test_tick_done_collision();
      test_disable_req();
      test_disable_wait();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/array_rf_sched.md
# array_rf_sched

Refresh scheduler that initiates the `rf_start`/`rf_done` handshake toward the array refresh controller. It counts the programmed refresh interval and accumulates owed refreshes, up to a postpone limit. It requests an array slot from the memory-controller main FSM, and on grant fires one refresh burst and waits for its completion. It sits between the APB config block, `fsm_ctrl`, and the array refresh controller.

## Interface
Parameters:
- `REFI_WIDTH`, 16, width of the refresh-interval counter and config.
- `PEND_MAX`, 8, maximum number of owed refreshes held (saturation point).
- `PEND_WIDTH`, 4, width of the pending counter; must satisfy PEND_MAX < 2^PEND_WIDTH.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `mc_rf_en`  in  1  refresh enable, from APB config.
- `mc_trefi_cfg`  in  REFI_WIDTH  refresh interval in clk cycles; 0 stops the timer.
- `mc_rf_urg_cfg`  in  PEND_WIDTH  pending level at which `rf_urgent` asserts; 0 disables urgency.
- `rf_req`  out  1  refresh slot request to `fsm_ctrl`.
- `rf_urgent`  out  1  pending ≥ `mc_rf_urg_cfg`; `fsm_ctrl` stops accepting new AXI commands.
- `rf_grant`  in  1  single-cycle grant from `fsm_ctrl`; the array is idle.
- `rf_start`  out  1  single-cycle pulse to the refresh controller.
- `rf_done`  in  1  single-cycle completion pulse from the refresh controller.
- `rf_busy`  out  1  a refresh burst is in flight (START or WAIT).
- `rf_pend_cnt`  out  PEND_WIDTH  owed refreshes.
- `rf_overflow`  out  1  sticky: a tick was lost at saturation.

## Operation
- Timer:
  - Counts 0..`mc_trefi_cfg`−1 while `mc_rf_en`=1 and cfg≠0.
  - `tick` is asserted when count = cfg−1; the timer then wraps to 0.
  - Otherwise the timer is held at 0.
- Pending counter:
  - Increments on `tick`.
  - Decrements on `rf_done` accepted in WAIT.
  - Tick and done in the same cycle: the value is unchanged.
  - Tick while at PEND_MAX with no simultaneous done: the value stays at PEND_MAX and `rf_overflow` is set.
- FSM states: IDLE, REQ, START, WAIT.
  - IDLE → REQ when pend≠0 and `mc_rf_en`=1.
  - REQ → START on `rf_grant`.
  - REQ → IDLE if `mc_rf_en` drops (request withdrawn).
  - START → WAIT unconditionally.
  - WAIT → IDLE on `rf_done`.
- `rf_done` outside WAIT and `rf_grant` outside REQ are ignored.
- Disabling (`mc_rf_en`=0):
  - The timer and pending count clear to 0.
  - `rf_overflow` clears.
  - An in-flight burst (START/WAIT) still completes normally; the decrement saturates at 0.
- `rf_urgent` = (cfg≠0) && (pend ≥ cfg).
- All comparisons are unsigned, at full config width.

## Timing
- All outputs are registered. Reset value of every output and internal register is 0, and the FSM resets to IDLE.
- `tick` at cycle N → `rf_pend_cnt` updated at N+1 → `rf_req` high at N+2 if the FSM was IDLE.
- `rf_req` is high exactly while the FSM is in REQ and stays high until grant.
- `rf_grant` sampled at cycle G → `rf_start` high for exactly cycle G+1, `rf_req` low from G+1, `rf_busy` high from G+1.
- `rf_done` sampled at cycle D:
  - `rf_busy` goes low at D+1 and the pending count decrements at D+1.
  - If pend remains ≠0, `rf_req` re-asserts at D+2.
- Back-to-back refreshes: minimum 3 cycles from one `rf_start` to the next, beyond the controller's burst time.
- `rf_urgent` follows `rf_pend_cnt` with 1 cycle of latency.
- Reset mid-burst drops all state immediately; the refresh controller is reset by the same `rst_n`.

## Structure
- Shared package `mc_pkg`:
  - FSM state encoding (`RF_SCH_IDLE/REQ/START/WAIT`, 2 bits).
  - Default `PEND_MAX`.
  - Config widths shared with the APB config block.
- One sub-module: `rf_interval_timer` (the counter plus `tick` generation, enable/cfg-zero handling).
- Pending counter and FSM stay in the top module.

## Test plan
- trefi=10, en=1, urg=0; grant 2 cycles after each req, done 5 cycles after each start → `rf_start` every 10 cycles, pend never exceeds 1, `rf_overflow`=0.
- trefi=4, grant withheld for 40 cycles, urg=6:
  - pend climbs to 8 and holds; `rf_overflow`=1; `rf_urgent`=1 once pend=6.
  - Then grants → 8 consecutive `rf_start` pulses, pend returns to 0.
- Same-cycle tick and `rf_done` with pend=3 → pend stays 3, FSM returns to IDLE, `rf_req` re-asserts 2 cycles later.
- `mc_rf_en` dropped in REQ with pend=2 → `rf_req` low next cycle, pend=0, timer=0, no `rf_start`.
- `mc_rf_en` dropped in WAIT → `rf_done` still accepted, `rf_busy` falls, pend stays 0; spurious `rf_done`/`rf_grant` in IDLE are ignored.
- Assert `rst_n` low in WAIT with pend=5 → all outputs 0 asynchronously; after release the first `rf_start` comes only after a fresh trefi interval.
